// File: rtl/dsm_mc_if.sv
// dsm_mc sample/control bundle.
// Source side drives samples and control; modulator drives pwm.
interface dsm_mc_if #(
   parameter int WIDTH    = 20,
   parameter int CHANNELS = 2
);
   logic                      enable;
   logic                      mode;
   logic [CHANNELS*WIDTH-1:0] vin;
   logic                      vin_valid;
   logic [CHANNELS-1:0]       pwm;

   modport master (
      output enable, mode, vin, vin_valid,
      input  pwm
   );

   modport slave (
      input  enable, mode, vin, vin_valid,
      output pwm
   );
endinterface

// File: rtl/dsm_mc.sv
// Multi-channel delta-sigma modulator.
// First- or second-order loop per channel, 1-bit output each.
module dsm_mc #(
   parameter int WIDTH    = 20,
   parameter int CHANNELS = 2
) (
   input logic     clock,
   input logic     reset_n,
   dsm_mc_if.slave bus
);
   localparam int IW = WIDTH + 3;
   localparam int SW = WIDTH + 4;

   localparam logic signed [SW-1:0] SMAX =
      {2'b00, {(IW-1){1'b1}}};
   localparam logic signed [SW-1:0] SMIN =
      {2'b11, {(IW-1){1'b0}}};
   localparam logic signed [SW-1:0] FS =
      {4'b0001, {WIDTH{1'b0}}};
   localparam logic signed [IW-1:0] TH =
      {4'b0001, {(WIDTH-1){1'b0}}};

   function automatic logic signed [IW-1:0] sat(
      input logic signed [SW-1:0] s
   );
      logic signed [IW-1:0] r;
      if (s > SMAX)
         r = SMAX[IW-1:0];
      else if (s < SMIN)
         r = SMIN[IW-1:0];
      else
         r = s[IW-1:0];
      return r;
   endfunction

   logic                mode_q;
   logic                clr;
   logic [CHANNELS-1:0] pwm_q;

   assign clr     = !bus.enable || (bus.mode != mode_q);
   assign bus.pwm = pwm_q;

   // Shared loop-order register; follows mode every edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         mode_q <= 1'b0;
      else
         mode_q <= bus.mode;
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [WIDTH-1:0]     x;
      logic [WIDTH-1:0]     acc;
      logic signed [IW-1:0] i1;
      logic signed [IW-1:0] i2;
      logic                 p;
      logic [WIDTH:0]       sum1;
      logic                 y;
      logic signed [SW-1:0] f;
      logic signed [SW-1:0] s1;
      logic signed [SW-1:0] s2;
      logic signed [IW-1:0] i1n;
      logic signed [IW-1:0] i2n;

      assign pwm_q[c] = p;

      // Next-state arithmetic for both loop orders.
      always_comb begin
         sum1 = {1'b0, acc} + {1'b0, x};
         y    = (i2 >= TH);
         f    = y ? FS : '0;
         s1   = {i1[IW-1], i1} + {4'b0000, x} - f;
         i1n  = sat(s1);
         s2   = {i2[IW-1], i2} + {i1n[IW-1], i1n} - f;
         i2n  = sat(s2);
      end

      // Sample hold and loop state; clears on disable or mode change.
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            x   <= '0;
            acc <= '0;
            i1  <= '0;
            i2  <= '0;
            p   <= 1'b0;
         end else begin
            if (bus.vin_valid)
               x <= bus.vin[c*WIDTH +: WIDTH];
            if (clr) begin
               acc <= '0;
               i1  <= '0;
               i2  <= '0;
               p   <= 1'b0;
            end else if (mode_q) begin
               acc <= '0;
               i1  <= i1n;
               i2  <= i2n;
               p   <= y;
            end else begin
               acc <= sum1[WIDTH-1:0];
               i1  <= '0;
               i2  <= '0;
               p   <= sum1[WIDTH];
            end
         end
      end
   end
endmodule
